ans_display_driver: RTL and testbench

//  Output end of the switch calculator: takes the 10-bit two's-complement result `ans` and `error` and drives a
//  4-digit multiplexed 7-segment display. Synchronises the switch-derived inputs, converts to sign + 3 BCD

---
 rtl/ans_display_driver.sv | 201 ++++++++++++++++++++
 tb/tb_ans_display_driver.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ans_display_driver.sv
// Calculator output stage: synchronises {error, ans}, converts it to sign + 3 BCD digits
// with a sequential double-dabble, and scans the result onto a 4-digit 7-segment display.
module ans_display_driver #(
    parameter int SCAN_DIV       = 1024,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] ans,
    input  logic       error,
    output logic [6:0] seg,
    output logic [3:0] dig_sel,
    output logic       upd_busy
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    localparam logic [6:0] SEG_MINUS = 7'b1000000;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_R     = 7'b1010000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [10:0]       r_sync1;
    logic [10:0]       r_sync2;
    logic [10:0]       r_shadow;

    logic              r_neg;
    logic [9:0]        r_mag;
    logic [11:0]       r_bcd;
    logic [3:0]        r_iter;

    logic              r_disp_err;
    logic              r_disp_neg;
    logic [3:0]        r_disp_h;
    logic [3:0]        r_disp_t;
    logic [3:0]        r_disp_o;

    logic [CNT_W-1:0]  r_scan_cnt;
    logic [1:0]        r_dig_idx;
    logic [6:0]        r_seg;
    logic [3:0]        r_dig_sel;

    logic [9:0]        w_abs;
    logic [11:0]       w_bcd_adj;
    logic [6:0]        w_seg_next;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Two's-complement magnitude; -512 wraps to 10'h200, which reads as 512 unsigned.
    assign w_abs = r_sync2[9] ? (~r_sync2[9:0] + 10'd1) : r_sync2[9:0];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dabble
            assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5)
                                        ? r_bcd[gi*4 +: 4] + 4'd3
                                        : r_bcd[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {error, ans};
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (r_sync2 != r_shadow) w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_SHIFT;
            S_SHIFT: if (r_iter == 4'd9) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign upd_busy = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow   <= '0;
            r_neg      <= 1'b0;
            r_mag      <= '0;
            r_bcd      <= '0;
            r_iter     <= '0;
            r_disp_err <= 1'b0;
            r_disp_neg <= 1'b0;
            r_disp_h   <= '0;
            r_disp_t   <= '0;
            r_disp_o   <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_shadow <= r_sync2;
                    r_neg    <= r_sync2[9];
                    r_mag    <= w_abs;
                    r_bcd    <= '0;
                    r_iter   <= '0;
                end
                S_SHIFT: begin
                    {r_bcd, r_mag} <= {w_bcd_adj[10:0], r_mag, 1'b0};
                    r_iter         <= r_iter + 4'd1;
                end
                S_DONE: begin
                    // All display fields change on the same edge so no mixed value is ever scanned.
                    r_disp_err <= r_shadow[10];
                    r_disp_neg <= r_neg;
                    r_disp_h   <= r_bcd[11:8];
                    r_disp_t   <= r_bcd[7:4];
                    r_disp_o   <= r_bcd[3:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_seg_next = 7'h00;
        case (r_dig_idx)
            2'd0: w_seg_next = r_disp_err ? 7'h00 : seg_of(r_disp_o);
            2'd1: begin
                if (r_disp_err)
                    w_seg_next = SEG_R;
                else if (r_disp_h != 4'd0 || r_disp_t != 4'd0)
                    w_seg_next = seg_of(r_disp_t);
            end
            2'd2: begin
                if (r_disp_err)
                    w_seg_next = SEG_R;
                else if (r_disp_h != 4'd0)
                    w_seg_next = seg_of(r_disp_h);
            end
            default: begin
                if (r_disp_err)
                    w_seg_next = SEG_E;
                else if (r_disp_neg)
                    w_seg_next = SEG_MINUS;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_dig_idx  <= '0;
            r_seg      <= '0;
            r_dig_sel  <= 4'b0001;
        end else begin
            if (r_scan_cnt == CNT_MAX) begin
                r_scan_cnt <= '0;
                r_dig_idx  <= r_dig_idx + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            r_seg     <= w_seg_next;
            r_dig_sel <= 4'b0001 << r_dig_idx;
        end
    end

    assign seg     = SEG_ACTIVE_LOW ? ~r_seg     : r_seg;
    assign dig_sel = SEG_ACTIVE_LOW ? ~r_dig_sel : r_dig_sel;

endmodule

// File: tb/tb_ans_display_driver.sv
// Self-checking bench for ans_display_driver: fixed vectors, random values against an
// arithmetic display model, and multi-cycle sequences for scan, re-conversion and reset.
module tb_ans_display_driver;

    localparam int SCAN_DIV = 4;

    logic       clk;
    logic       rst_n;
    logic [9:0] ans;
    logic       error;
    logic [6:0] seg;
    logic [3:0] dig_sel;
    logic       upd_busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [10:0] last_in;

    localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    ans_display_driver #(.SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ans      (ans),
        .error    (error),
        .seg      (seg),
        .dig_sel  (dig_sel),
        .upd_busy (upd_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  a;
        logic        e;
        logic [27:0] exp;   // {sign, hundreds, tens, ones}
    } vec_t;

    // Display model straight from the decimal rules: plain integer division.
    function automatic logic [27:0] model(input logic [9:0] a, input logic e);
        int v, m, h, t, o;
        logic [6:0] s3, s2, s1, s0;
        if (e) return {7'h79, 7'h50, 7'h50, 7'h00};
        v = int'($signed(a));
        m = (v < 0) ? -v : v;
        h = m / 100;
        t = (m / 10) % 10;
        o = m % 10;
        s3 = (v < 0) ? 7'h40 : 7'h00;
        s2 = (h != 0) ? SEG_TAB[h] : 7'h00;
        s1 = (m >= 10) ? SEG_TAB[t] : 7'h00;
        s0 = SEG_TAB[o];
        return {s3, s2, s1, s0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [3:0] ds);
        case (ds)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic read_display(output logic [27:0] d);
        logic [3:0] seen;
        int k;
        seen = '0;
        d = '0;
        for (int i = 0; i < 4 * SCAN_DIV + 4; i++) begin
            @(negedge clk);
            k = idx_of(dig_sel);
            if (k >= 0) begin
                d[k*7 +: 7] = seg;
                seen[k] = 1'b1;
            end
        end
        check("scan_coverage", {28'd0, seen}, 32'hF);
    endtask

    task automatic run_vec(input logic [9:0] a, input logic e, input logic [27:0] exp, input string name);
        int w;
        logic [27:0] got;
        @(negedge clk);
        ans = a;
        error = e;
        if ({e, a} != last_in) begin
            w = 0;
            while (!upd_busy && w < 10) begin
                @(negedge clk);
                w++;
            end
            check({name, "_busy_rise"}, {31'd0, upd_busy}, 32'd1);
            w = 0;
            while (upd_busy && w < 40) begin
                @(negedge clk);
                w++;
            end
            check({name, "_busy_len"}, w, 32'd12);
        end
        last_in = {e, a};
        repeat (2) @(negedge clk);
        read_display(got);
        check(name, {4'd0, got}, {4'd0, exp});
        $display("vec %s ans=%h err=%0d disp=%h", name, a, e, got);
    endtask

    vec_t vecs [10];
    logic [27:0] got;
    logic [27:0] m_prev, m5, m9;
    int rises, bad_seen, busy_cnt, k, run_len;
    logic prev_busy, changed;
    logic [3:0] prev_ds;
    logic [9:0] ra;
    logic re;

    initial begin
        vecs[0] = '{10'd123,  1'b0, {7'h00, 7'h06, 7'h5B, 7'h4F}};
        vecs[1] = '{10'h3FF,  1'b0, {7'h40, 7'h00, 7'h00, 7'h06}};
        vecs[2] = '{10'h200,  1'b0, {7'h40, 7'h6D, 7'h06, 7'h5B}};
        vecs[3] = '{10'd57,   1'b1, {7'h79, 7'h50, 7'h50, 7'h00}};
        vecs[4] = '{10'd57,   1'b0, {7'h00, 7'h00, 7'h6D, 7'h07}};
        vecs[5] = '{10'd0,    1'b0, {7'h00, 7'h00, 7'h00, 7'h3F}};
        vecs[6] = '{10'd100,  1'b0, {7'h00, 7'h06, 7'h3F, 7'h3F}};
        vecs[7] = '{10'd7,    1'b0, {7'h00, 7'h00, 7'h00, 7'h07}};
        vecs[8] = '{10'd511,  1'b0, {7'h00, 7'h6D, 7'h06, 7'h06}};
        vecs[9] = '{10'h3F6,  1'b0, {7'h40, 7'h00, 7'h06, 7'h3F}};

        // Reset state and idle display
        rst_n = 1'b0;
        ans = '0;
        error = 1'b0;
        last_in = '0;
        repeat (3) @(negedge clk);
        check("rst_seg", {25'd0, seg}, 32'h0);
        check("rst_dig_sel", {28'd0, dig_sel}, 32'h1);
        check("rst_busy", {31'd0, upd_busy}, 32'h0);
        rst_n = 1'b1;
        rises = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (upd_busy) rises++;
        end
        check("idle_no_busy", rises, 0);
        read_display(got);
        check("rst_display", {4'd0, got}, {4'd0, 7'h00, 7'h00, 7'h00, 7'h3F});

        for (int i = 0; i < 10; i++)
            run_vec(vecs[i].a, vecs[i].e, vecs[i].exp, $sformatf("tab%0d", i));

        // Input changes mid-conversion: only old, 5 or 9 may ever appear, 9 must win
        m_prev = model(last_in[9:0], last_in[10]);
        m5 = model(10'd5, 1'b0);
        m9 = model(10'd9, 1'b0);
        @(negedge clk);
        ans = 10'd5;
        error = 1'b0;
        rises = 0;
        bad_seen = 0;
        busy_cnt = 0;
        changed = 1'b0;
        prev_busy = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (upd_busy && !prev_busy) rises++;
            prev_busy = upd_busy;
            if (rises == 1 && upd_busy) busy_cnt++;
            if (!changed && busy_cnt == 5) begin
                ans = 10'd9;
                changed = 1'b1;
            end
            k = idx_of(dig_sel);
            if (k < 0) bad_seen++;
            else if (seg != m_prev[k*7 +: 7] && seg != m5[k*7 +: 7] && seg != m9[k*7 +: 7])
                bad_seen++;
        end
        check("reconv_changed", {31'd0, changed}, 32'd1);
        check("reconv_pulses", rises, 2);
        check("reconv_no_glitch", bad_seen, 0);
        read_display(got);
        check("reconv_final", {4'd0, got}, {4'd0, m9});
        last_in = {1'b0, 10'd9};
        $display("vec reconv 5->9 disp=%h", got);

        // Random values against the arithmetic model
        for (int i = 0; i < 25; i++) begin
            ra = 10'($urandom);
            re = ($urandom_range(0, 7) == 0);
            if ({re, ra} == last_in) ra = ra ^ 10'd1;
            run_vec(ra, re, model(ra, re), $sformatf("rnd%0d", i));
        end

        // Scan order and dwell time
        prev_ds = dig_sel;
        run_len = 0;
        k = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dig_sel == prev_ds) begin
                run_len++;
            end else begin
                if (k > 0) check("scan_dwell", run_len + 1, SCAN_DIV);
                check("scan_order", {28'd0, dig_sel},
                      {28'd0, (prev_ds == 4'b1000) ? 4'b0001 : (prev_ds << 1)});
                k++;
                run_len = 0;
                prev_ds = dig_sel;
            end
        end

        // Reset in the middle of SHIFT
        @(negedge clk);
        ans = 10'd321;
        for (int i = 0; i < 10 && !upd_busy; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("pre_rst_busy", {31'd0, upd_busy}, 32'd1);
        rst_n = 1'b0;
        ans = 10'd0;
        error = 1'b0;
        #1;
        check("midrst_seg", {25'd0, seg}, 32'h0);
        check("midrst_dig_sel", {28'd0, dig_sel}, 32'h1);
        check("midrst_busy", {31'd0, upd_busy}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_in = '0;
        rises = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (upd_busy) rises++;
        end
        check("midrst_no_busy", rises, 0);
        read_display(got);
        check("midrst_display", {4'd0, got}, {4'd0, 7'h00, 7'h00, 7'h00, 7'h3F});
        $display("vec midrst disp=%h", got);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
